depth_buffer_ctrl: RTL

DEPTH_BUFFER_CTRL -- requirements
Module: depth_buffer_ctrl

---
 rtl/raster_pkg.sv | 29 ++
 rtl/depth_ram.sv | 26 ++
 rtl/depth_buffer_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared raster types: depth/address/color typedefs, far-plane depth constant,
// controller state encoding and a saturating statistics increment.
package raster_pkg;

  localparam int DEPTH_W = 12;
  localparam int ADDR_W  = 15;
  localparam int COLOR_W = 4;

  typedef logic [DEPTH_W-1:0] depth_t;
  typedef logic [ADDR_W-1:0]  fb_addr_t;
  typedef logic [COLOR_W-1:0] color_idx_t;

  localparam depth_t DEPTH_FAR = {DEPTH_W{1'b1}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } db_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/depth_ram.sv
// Simple dual-port depth store: one write port, one synchronous read port
// with one cycle of read latency (read-during-write returns the old word).
module depth_ram #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:DEPTH-1];

  // Storage write and registered read
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/depth_buffer_ctrl.sv
// Z-buffer controller: 3-stage accept/read/compare pipeline with a full-frame clear.
// Define DEPTH_STATS_EN to build the saturating pass/fail fragment counters.
module depth_buffer_ctrl
  import raster_pkg::*;
#(
  parameter int FB_WIDTH      = 160,
  parameter int FB_HEIGHT     = 120,
  parameter int FB_ADDR_WIDTH = $clog2(FB_WIDTH * FB_HEIGHT),
  parameter int DB_DATA_WIDTH = $bits(depth_t),
  parameter int FB_DATA_WIDTH = $bits(color_idx_t)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic [FB_ADDR_WIDTH-1:0] i_addr,
  input  logic [DB_DATA_WIDTH-1:0] i_depth,
  input  logic [FB_DATA_WIDTH-1:0] i_color,
  output logic                     o_ready,
  input  logic                     i_clear,
  output logic                     o_busy,
  output logic                     o_clear_done,
  output logic                     o_fb_we,
  output logic [FB_ADDR_WIDTH-1:0] o_fb_addr,
  output logic [FB_DATA_WIDTH-1:0] o_fb_data,
  output logic [15:0]              o_pass_cnt,
  output logic [15:0]              o_fail_cnt
);

  localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR   = FB_ADDR_WIDTH'(FB_PIXELS - 32'd1);
  localparam logic [FB_ADDR_WIDTH-1:0] ADDR_ZERO   = {FB_ADDR_WIDTH{1'b0}};
  localparam logic [FB_ADDR_WIDTH-1:0] ADDR_ONE    = FB_ADDR_WIDTH'(1'b1);
  localparam logic [DB_DATA_WIDTH-1:0] CLEAR_DEPTH = {DB_DATA_WIDTH{DEPTH_FAR[0]}};

  db_state_e                state_q, state_d;
  logic [FB_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                     clr_act_q, clr_act_d;
  logic                     clear_done_q, clear_done_d;

  logic                     s0_valid_q;
  logic [FB_ADDR_WIDTH-1:0] s0_addr_q;
  logic [DB_DATA_WIDTH-1:0] s0_depth_q;
  logic [FB_DATA_WIDTH-1:0] s0_color_q;

  logic                     s1_valid_q;
  logic [FB_ADDR_WIDTH-1:0] s1_addr_q;
  logic [DB_DATA_WIDTH-1:0] s1_depth_q;
  logic [FB_DATA_WIDTH-1:0] s1_color_q;
  logic                     s1_fwd_q;
  logic [DB_DATA_WIDTH-1:0] s1_fwd_depth_q;

  logic                     ready_s;
  logic                     accept_s;
  logic                     fwd_s;
  logic                     pass_s;
  logic [DB_DATA_WIDTH-1:0] stored_s;
  logic [DB_DATA_WIDTH-1:0] ram_rdata_s;
  logic                     ram_we_s;
  logic [FB_ADDR_WIDTH-1:0] ram_waddr_s;
  logic [DB_DATA_WIDTH-1:0] ram_wdata_s;

  // The clear request itself closes the door, so a same-cycle fragment is refused.
  assign ready_s  = (state_q == ST_RUN) && !i_clear;
  assign accept_s = i_valid && ready_s;

  // FSM next state, clear address sweep and done pulse
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_act_d = clr_act_q;
    case (state_q)
      ST_RUN: begin
        if (i_clear) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!s0_valid_q && !s1_valid_q) begin
          state_d   = ST_CLEAR;
          clr_act_d = 1'b1;
          cnt_d     = ADDR_ZERO;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        // Out of reset the sweep arms for one cycle so no write is shown under reset.
        if (!clr_act_q) begin
          clr_act_d = 1'b1;
        end else if (cnt_q == LAST_ADDR) begin
          clr_act_d = 1'b0;
          cnt_d     = ADDR_ZERO;
          state_d   = ST_RUN;
        end else begin
          cnt_d = cnt_q + ADDR_ONE;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_act_d = 1'b0;
        cnt_d     = ADDR_ZERO;
      end
    endcase
    clear_done_d = (state_d == ST_CLEAR) && clr_act_d && (cnt_d == LAST_ADDR);
  end

  // FSM and clear-sweep registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= ADDR_ZERO;
      clr_act_q    <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_act_q    <= clr_act_d;
      clear_done_q <= clear_done_d;
    end
  end

  // S0: capture the accepted fragment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_addr_q  <= ADDR_ZERO;
      s0_depth_q <= {DB_DATA_WIDTH{1'b0}};
      s0_color_q <= {FB_DATA_WIDTH{1'b0}};
    end else begin
      s0_valid_q <= accept_s;
      if (accept_s) begin
        s0_addr_q  <= i_addr;
        s0_depth_q <= i_depth;
        s0_color_q <= i_color;
      end
    end
  end

  // A compare-stage write to the address being read now would be missed by the RAM.
  assign fwd_s = pass_s && s0_valid_q && (s1_addr_q == s0_addr_q);

  // S1: fragment travels alongside its depth read, plus any forwarded depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_addr_q      <= ADDR_ZERO;
      s1_depth_q     <= {DB_DATA_WIDTH{1'b0}};
      s1_color_q     <= {FB_DATA_WIDTH{1'b0}};
      s1_fwd_q       <= 1'b0;
      s1_fwd_depth_q <= {DB_DATA_WIDTH{1'b0}};
    end else begin
      s1_valid_q     <= s0_valid_q;
      s1_addr_q      <= s0_addr_q;
      s1_depth_q     <= s0_depth_q;
      s1_color_q     <= s0_color_q;
      s1_fwd_q       <= fwd_s;
      s1_fwd_depth_q <= s1_depth_q;
    end
  end

  // S2: depth test (equal depth loses) and write-port steering
  always_comb begin
    if (s1_fwd_q) begin
      stored_s = s1_fwd_depth_q;
    end else begin
      stored_s = ram_rdata_s;
    end
    pass_s = s1_valid_q && (s1_depth_q < stored_s);
    if (clr_act_q) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = cnt_q;
      ram_wdata_s = CLEAR_DEPTH;
      o_fb_addr   = cnt_q;
      o_fb_data   = {FB_DATA_WIDTH{1'b0}};
    end else begin
      ram_we_s    = pass_s;
      ram_waddr_s = s1_addr_q;
      ram_wdata_s = s1_depth_q;
      o_fb_addr   = s1_addr_q;
      o_fb_data   = s1_color_q;
    end
  end

  depth_ram #(
    .DEPTH (FB_PIXELS),
    .AW    (FB_ADDR_WIDTH),
    .DW    (DB_DATA_WIDTH)
  ) u_depth_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (ram_wdata_s),
    .raddr_i (s0_addr_q),
    .rdata_o (ram_rdata_s)
  );

  assign o_ready      = ready_s;
  assign o_busy       = (state_q != ST_RUN);
  assign o_clear_done = clear_done_q;
  assign o_fb_we      = ram_we_s;

`ifdef DEPTH_STATS_EN
  logic [15:0] pass_cnt_q;
  logic [15:0] fail_cnt_q;
  logic        stats_clr_s;

  assign stats_clr_s = (state_q == ST_DRAIN) && (state_d == ST_CLEAR);

  // Saturating fragment statistics, zeroed when a clear starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= 16'h0000;
      fail_cnt_q <= 16'h0000;
    end else if (stats_clr_s) begin
      pass_cnt_q <= 16'h0000;
      fail_cnt_q <= 16'h0000;
    end else if (s1_valid_q) begin
      if (pass_s) begin
        pass_cnt_q <= sat_inc16(pass_cnt_q);
      end else begin
        fail_cnt_q <= sat_inc16(fail_cnt_q);
      end
    end
  end

  assign o_pass_cnt = pass_cnt_q;
  assign o_fail_cnt = fail_cnt_q;
`else
  assign o_pass_cnt = 16'h0000;
  assign o_fail_cnt = 16'h0000;
`endif

endmodule
